// File: rtl/bitblade_psum_pkg.sv
// rtl/bitblade_psum_pkg.sv - shared widths, state encoding, limits and term shifter for psum_accumulator
package bitblade_psum_pkg;

  localparam int PSUM_DATA_W  = 32;
  localparam int PSUM_ACC_W   = 48;
  localparam int PSUM_SHIFT_W = 4;
  localparam int PSUM_CNT_W   = 8;
  // Wide enough to hold a fully shifted term so overflow past ACC_W can be seen.
  localparam int PSUM_WIDE_W  = PSUM_ACC_W + (1 << PSUM_SHIFT_W) - 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } psum_state_e;

  localparam logic [PSUM_ACC_W-1:0] ACC_MAX = {1'b0, {(PSUM_ACC_W-1){1'b1}}};
  localparam logic [PSUM_ACC_W-1:0] ACC_MIN = {1'b1, {(PSUM_ACC_W-1){1'b0}}};

  function automatic logic [PSUM_WIDE_W-1:0] shift_wide(
    input logic [PSUM_DATA_W-1:0]  d,
    input logic [PSUM_SHIFT_W-1:0] s
  );
    logic [PSUM_WIDE_W-1:0] ext;
    ext = {{(PSUM_WIDE_W-PSUM_DATA_W){d[PSUM_DATA_W-1]}}, d};
    return ext << s;
  endfunction

  // Term overflows when the bits above the ACC_W sign bit are not a pure sign extension.
  function automatic logic shift_ovf(
    input logic [PSUM_DATA_W-1:0]  d,
    input logic [PSUM_SHIFT_W-1:0] s
  );
    logic [PSUM_WIDE_W-1:0]            wide;
    logic [PSUM_WIDE_W-PSUM_ACC_W:0]   top;
    wide = shift_wide(d, s);
    top  = wide[PSUM_WIDE_W-1:PSUM_ACC_W-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic [PSUM_ACC_W-1:0] shift_term(
    input logic [PSUM_DATA_W-1:0]  d,
    input logic [PSUM_SHIFT_W-1:0] s,
    input logic                    sat
  );
    logic [PSUM_WIDE_W-1:0] wide;
    logic [PSUM_ACC_W-1:0]  r;
    wide = shift_wide(d, s);
    if (sat && shift_ovf(d, s)) r = d[PSUM_DATA_W-1] ? ACC_MIN : ACC_MAX;
    else                        r = wide[PSUM_ACC_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// rtl/psum_sat_add.sv - ACC_W signed adder; clamps and flags overflow when PSUM_SAT_EN is defined
module psum_sat_add
  import bitblade_psum_pkg::*;
(
  input  logic [PSUM_ACC_W-1:0] a,
  input  logic [PSUM_ACC_W-1:0] b,
  output logic [PSUM_ACC_W-1:0] sum,
  output logic                  ovf
);

  logic [PSUM_ACC_W-1:0] raw;

  assign raw = a + b;

`ifdef PSUM_SAT_EN
  // Signed overflow: operands agree in sign but the result does not.
  assign ovf = (a[PSUM_ACC_W-1] == b[PSUM_ACC_W-1]) && (raw[PSUM_ACC_W-1] != a[PSUM_ACC_W-1]);
  assign sum = ovf ? (a[PSUM_ACC_W-1] ? ACC_MIN : ACC_MAX) : raw;
`else
  assign ovf = 1'b0;
  assign sum = raw;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - shift-and-accumulate of first..last partial-sum groups, valid/ready output
// Optional saturation: define PSUM_SAT_EN.
module psum_accumulator
  import bitblade_psum_pkg::*;
#(
  parameter int DATA_W  = PSUM_DATA_W,
  parameter int ACC_W   = PSUM_ACC_W,
  parameter int SHIFT_W = PSUM_SHIFT_W,
  parameter int CNT_W   = PSUM_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHIFT_W-1:0] shift_amt,
  input  logic               in_first,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc_out,
  output logic [CNT_W-1:0]   beat_cnt,
  output logic               sat_flag,
  output logic               proto_err
);

`ifdef PSUM_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  psum_state_e      state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_b;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             start;
  logic             add_ovf;
  logic             term_ovf;
  logic             grp_sat;
  logic             grp_sat_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // An unflagged beat in IDLE still opens a group.
  assign start    = in_first || (state == IDLE);

  assign add_b    = shift_term(data_in, shift_amt, SAT_EN);
  assign term_ovf = SAT_EN && shift_ovf(data_in, shift_amt);
  assign add_a    = start ? '0 : acc;

  psum_sat_add u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (sum),
    .ovf (add_ovf)
  );

  assign cnt_next     = start ? CNT_W'(1) : ((&cnt) ? cnt : cnt + 1'b1);
  assign grp_sat_next = (start ? 1'b0 : grp_sat) | term_ovf | add_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      grp_sat   <= 1'b0;
      out_valid <= 1'b0;
      acc_out   <= '0;
      beat_cnt  <= '0;
      sat_flag  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= accept && (((state == IDLE) && !in_first) || ((state == ACC) && in_first));
      if (accept) begin
        acc     <= sum;
        cnt     <= cnt_next;
        grp_sat <= grp_sat_next;
        state   <= in_last ? IDLE : ACC;
      end
      // A new result may load on the same edge the previous one is popped.
      if (accept && in_last) begin
        out_valid <= 1'b1;
        acc_out   <= sum;
        beat_cnt  <= cnt_next;
        sat_flag  <= grp_sat_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
